// File: rtl/axi4lite_master_bridge_pkg.sv
// axi4lite_master_bridge_pkg: AXI4-Lite response codes, protection default and bridge FSM states.
// Revision: 1.0
`default_nettype none

package axi4lite_master_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } bridge_state_t;

endpackage

`default_nettype wire

// File: rtl/axi4lite_master_bridge.sv
// axi4lite_master_bridge: single-outstanding AXI4-Lite initiator turning register commands into
// AXI4-Lite transactions, one response per command, with a saturating per-transaction latency count.
// Revision: 1.0
`default_nettype none

module axi4lite_master_bridge
    import axi4lite_master_bridge_pkg::*;
#(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    parameter int  CNT_W  = 16,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [CNT_W-1:0]  txn_cycles,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [2:0]        M_AXI_AWPROT,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    output logic [DATA_W-1:0] M_AXI_WDATA,
    output logic [STRB_W-1:0] M_AXI_WSTRB,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    input  logic [1:0]        M_AXI_BRESP,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARPROT,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bridge_state_t     state;
    bridge_state_t     state_nxt;
    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic busy;

    assign accept = cmd_valid && cmd_ready;
    assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;
    assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;
    assign busy   = (state == ST_WR_AW_W) || (state == ST_WR_B) ||
                    (state == ST_RD_AR) || (state == ST_RD_R);

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
    assign M_AXI_ARPROT = AXI_PROT_DEFAULT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Channel handshake signals decode straight from state so an async reset drops them at once.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_write ? ST_WR_AW_W : ST_RD_AR;
                end
            end
            ST_WR_AW_W: begin
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = ST_WR_B;
                end
            end
            ST_WR_B: begin
                M_AXI_BREADY = 1'b1;
                if (b_hs) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RD_AR: begin
                M_AXI_ARVALID = 1'b1;
                if (ar_hs) begin
                    state_nxt = ST_RD_R;
                end
            end
            ST_RD_R: begin
                M_AXI_RREADY = 1'b1;
                if (r_hs) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_resp   <= AXI_RESP_OKAY;
            txn_cycles <= '0;
        end else begin
            if (accept) begin
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
                addr_q     <= cmd_addr;
                wdata_q    <= cmd_wdata;
                wstrb_q    <= cmd_wstrb;
                rsp_write  <= cmd_write;
                txn_cycles <= '0;
            end else if (busy && (txn_cycles != CNT_MAX)) begin
                txn_cycles <= txn_cycles + CNT_W'(1);
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
            if (b_hs) begin
                rsp_resp  <= M_AXI_BRESP;
                rsp_rdata <= '0;
            end
            if (r_hs) begin
                rsp_resp  <= M_AXI_RRESP;
                rsp_rdata <= M_AXI_RDATA;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_master_bridge.sv
// tb_axi4lite_master_bridge: scoreboard bench with a behavioural AXI4-Lite register slave.
// Revision: 1.0
`default_nettype none

module tb_axi4lite_master_bridge;
    import axi4lite_master_bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] txn_cycles;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;

    axi4lite_master_bridge #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .txn_cycles(txn_cycles),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [15:0] cycles;
    } exp_t;
    exp_t sb_q[$];

    // Reference register file and the slave's own storage, kept separate on purpose.
    logic [31:0] ref_mem [16];
    logic [31:0] s_mem   [16];

    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [1:0] s_bresp, s_rresp;
    int hold_cnt = 0;
    logic rand_ready = 1'b0;

    // Behavioural slave: each READY/VALID rises after the programmed number of waiting cycles.
    initial begin
        logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
        logic aw_got, w_got, b_pend, r_pend;
        logic [31:0] a_awaddr, a_wdata, a_araddr;
        logic [3:0]  a_wstrb;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        a_awaddr = 0; a_wdata = 0; a_araddr = 0; a_wstrb = 0;
        forever begin
            @(negedge clk);
            hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
            hs_w  = M_AXI_WVALID && M_AXI_WREADY;
            hs_b  = M_AXI_BVALID && M_AXI_BREADY;
            hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
            hs_r  = M_AXI_RVALID && M_AXI_RREADY;
            if (hs_aw) a_awaddr = M_AXI_AWADDR;
            if (hs_w) begin a_wdata = M_AXI_WDATA; a_wstrb = M_AXI_WSTRB; end
            if (hs_ar) a_araddr = M_AXI_ARADDR;
            @(posedge clk);
            #1;
            if (rst) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                continue;
            end
            if (hs_aw) begin M_AXI_AWREADY = 0; aw_got = 1; end
            if (hs_w)  begin M_AXI_WREADY = 0;  w_got = 1;  end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                if (s_bresp == AXI_RESP_OKAY)
                    for (int i = 0; i < 4; i++)
                        if (a_wstrb[i]) s_mem[a_awaddr[5:2]][8*i +: 8] = a_wdata[8*i +: 8];
            end
            if (hs_b)  M_AXI_BVALID = 0;
            if (hs_ar) begin M_AXI_ARREADY = 0; r_pend = 1; r_cnt = 0; end
            if (hs_r)  M_AXI_RVALID = 0;
            if (M_AXI_AWVALID && !M_AXI_AWREADY) begin
                if (aw_cnt >= aw_wait) M_AXI_AWREADY = 1; else aw_cnt++;
            end
            if (M_AXI_WVALID && !M_AXI_WREADY) begin
                if (w_cnt >= w_wait) M_AXI_WREADY = 1; else w_cnt++;
            end
            if (M_AXI_ARVALID && !M_AXI_ARREADY) begin
                if (ar_cnt >= ar_wait) M_AXI_ARREADY = 1; else ar_cnt++;
            end
            if (b_pend) begin
                if (b_cnt >= b_wait) begin M_AXI_BVALID = 1; M_AXI_BRESP = s_bresp; b_pend = 0; end
                else b_cnt++;
            end
            if (r_pend) begin
                if (r_cnt >= r_wait) begin
                    M_AXI_RVALID = 1; M_AXI_RRESP = s_rresp; M_AXI_RDATA = s_mem[a_araddr[5:2]]; r_pend = 0;
                end else r_cnt++;
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) hold_cnt--;
            end else begin
                rsp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Monitor: scoreboard pop on response handshake plus channel-hold rules.
    initial begin
        logic        p_rsp, p_aw, p_w, p_ar;
        logic [51:0] p_rsp_vec;
        logic [32:0] p_aw_vec, p_ar_vec;
        logic [36:0] p_w_vec;
        exp_t        e;
        p_rsp = 0; p_aw = 0; p_w = 0; p_ar = 0;
        p_rsp_vec = 0; p_aw_vec = 0; p_ar_vec = 0; p_w_vec = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_rsp = 0; p_aw = 0; p_w = 0; p_ar = 0;
                continue;
            end
            if (rsp_valid) begin
                check("rsp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
                check("rsp_axi_quiet", {61'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 64'd0);
            end
            if (p_rsp) check("rsp_stable", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, txn_cycles}, p_rsp_vec);
            if (p_aw)  check("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, p_aw_vec);
            if (p_w)   check("w_hold", {M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB}, p_w_vec);
            if (p_ar)  check("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, p_ar_vec);
            if (M_AXI_BREADY) check("bready_after_aw_w", {62'd0, M_AXI_AWVALID, M_AXI_WVALID}, 64'd0);
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=none");
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_write", {63'd0, rsp_write}, {63'd0, e.write});
                    check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                    check("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.resp});
                    check("txn_cycles", {48'd0, txn_cycles}, {48'd0, e.cycles});
                end
            end
            p_rsp     = rsp_valid && !rsp_ready;
            p_rsp_vec = {rsp_valid, rsp_write, rsp_rdata, rsp_resp, txn_cycles};
            p_aw      = M_AXI_AWVALID && !M_AXI_AWREADY;
            p_aw_vec  = {M_AXI_AWVALID, M_AXI_AWADDR};
            p_w       = M_AXI_WVALID && !M_AXI_WREADY;
            p_w_vec   = {M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB};
            p_ar      = M_AXI_ARVALID && !M_AXI_ARREADY;
            p_ar_vec  = {M_AXI_ARVALID, M_AXI_ARADDR};
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aww, input int ww, input int bw,
                         input int arw, input int rw, input logic [1:0] resp);
        int   guard;
        exp_t e;
        @(posedge clk);
        #1;
        guard = 0;
        while (!cmd_ready && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL cmd_ready_timeout actual=0 required=1");
            return;
        end
        aw_wait = aww; w_wait = ww; b_wait = bw; ar_wait = arw; r_wait = rw;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        s_bresp = resp; s_rresp = resp;
        e.write = wr;
        e.resp  = resp;
        if (wr) begin
            e.rdata  = 32'd0;
            e.cycles = 16'(2 + ((aww > ww) ? aww : ww) + bw);
            if (resp == AXI_RESP_OKAY)
                for (int i = 0; i < 4; i++)
                    if (strb[i]) ref_mem[addr[5:2]][8*i +: 8] = data[8*i +: 8];
        end else begin
            e.rdata  = ref_mem[addr[5:2]];
            e.cycles = 16'(2 + arw + rw);
        end
        sb_q.push_back(e);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    endtask

    initial begin
        int guard;
        logic [1:0] rr;
        for (int i = 0; i < 16; i++) begin ref_mem[i] = 32'd0; s_mem[i] = 32'd0; end
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        s_bresp = AXI_RESP_OKAY; s_rresp = AXI_RESP_OKAY;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rst = 1'b1;
        #12;
        check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_fields", {rsp_write, rsp_rdata, rsp_resp}, 64'd0);
        check("reset_txn_cycles", {48'd0, txn_cycles}, 64'd0);
        check("reset_axi_valid_ready", {59'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 64'd0);
        check("reset_axi_payload", {M_AXI_AWADDR, M_AXI_WDATA}, 64'd0);
        check("reset_prot_strb", {54'd0, M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic write then read back, zero-wait slave.
        issue(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        issue(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        // Partial-strobe merge.
        issue(1, 32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        issue(1, 32'h8, 32'h00AA5500, 4'h6, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        issue(0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        check("merge_model", {32'd0, ref_mem[2]}, 64'hFFAA55FF);
        // Late AWREADY, early WREADY.
        issue(1, 32'hC, 32'h0BADF00D, 4'hF, 3, 0, 0, 0, 0, AXI_RESP_OKAY);
        @(posedge clk);
        #1;
        check("w_dropped_aw_held", {61'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 64'h4);
        // Response back-pressure.
        hold_cnt = 5;
        issue(0, 32'hC, 32'h0, 4'h0, 0, 0, 1, 0, 0, AXI_RESP_OKAY);
        issue(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 2, 1, AXI_RESP_OKAY);
        // Error responses pass through.
        issue(1, 32'h10, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        issue(1, 32'h10, 32'hCAFEBABE, 4'hF, 1, 2, 0, 0, 0, AXI_RESP_SLVERR);
        issue(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 1, 0, AXI_RESP_DECERR);
        // Reset while ARVALID waits for ARREADY.
        issue(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 10, 0, AXI_RESP_OKAY);
        repeat (2) @(posedge clk);
        #1;
        check("arvalid_before_reset", {63'd0, M_AXI_ARVALID}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check("reset_mid_arvalid", {62'd0, M_AXI_ARVALID, rsp_valid}, 64'd0);
        check("reset_mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        void'(sb_q.pop_back());
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, AXI_RESP_OKAY);

        // Randomized traffic.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : AXI_RESP_OKAY;
            issue(1'($urandom), {26'd0, 4'($urandom), 2'b00}, $urandom, 4'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rr);
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
